// File: rtl/param_mac_engine.sv
// param_mac_engine
//   Matrix-product engine: R[i][j] = sum_k IN[i][k] * WT[j][k].
//   Each matrix starts at a header word {rows, cols}. Its elements follow
//   row-major from base+1, one per word, in the low DATA_W bits.
//   Results are written i-major to res_base + i*wt_rows + j.
//
//   Build option: define PARAM_MAC_SATURATE_EN to saturate each result to the
//   signed 2*DATA_W range. Without it, the low 2*DATA_W accumulator bits are
//   written (wrap).
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start / ready / done / err  job handshake; err flags a rejected job
//   in_base, wt_base, res_base  header addresses and first result address
//   in_rd_addr / in_rd_data     input-matrix SRAM read port (RD_LAT latency)
//   wt_rd_addr / wt_rd_data     weight-matrix SRAM read port (RD_LAT latency)
//   res_wr_en/_addr/_data       result write port
//   in_rows..wt_cols            dimensions captured from the last headers
module param_mac_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 40,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic [ADDR_W-1:0] res_base,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [2*DATA_W-1:0] in_rd_data,
  input  logic [2*DATA_W-1:0] wt_rd_data,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [2*DATA_W-1:0] res_wr_data,
  output logic [DATA_W-1:0] in_rows,
  output logic [DATA_W-1:0] in_cols,
  output logic [DATA_W-1:0] wt_rows,
  output logic [DATA_W-1:0] wt_cols
);

  localparam int PW = 2 * DATA_W;
  localparam logic [2:0] HDR_LAST   = 3'(RD_LAT - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT + 1);
  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_SAVE, DOT_ISSUE, DOT_DRAIN, WRITE, FINISH} state_t;

  state_t              state_reg;
  logic                ready_reg, done_reg, err_reg, res_wr_en_reg;
  logic [ADDR_W-1:0]   res_wr_addr_reg, in_rd_addr_reg, wt_rd_addr_reg;
  logic [PW-1:0]       res_wr_data_reg;
  logic [ADDR_W-1:0]   in_base_reg, wt_base_reg, res_base_reg;
  logic [ADDR_W-1:0]   in_row_ptr_reg, wt_row_ptr_reg, res_addr_reg;
  logic [DATA_W-1:0]   in_rows_reg, in_cols_reg, wt_rows_reg, wt_cols_reg;
  logic [DATA_W-1:0]   i_reg, j_reg, k_reg;
  logic [2:0]          wait_cnt_reg;

  // Header fields straight off the read ports (valid in HDR_SAVE)
  logic [DATA_W-1:0] hdr_in_rows, hdr_in_cols, hdr_wt_rows, hdr_wt_cols;
  logic              hdr_bad;
  assign hdr_in_rows = in_rd_data[PW-1:DATA_W];
  assign hdr_in_cols = in_rd_data[DATA_W-1:0];
  assign hdr_wt_rows = wt_rd_data[PW-1:DATA_W];
  assign hdr_wt_cols = wt_rd_data[DATA_W-1:0];
  assign hdr_bad = (hdr_in_cols != hdr_wt_cols) || (hdr_in_rows == '0) || (hdr_in_cols == '0) ||
                   (hdr_wt_rows == '0) || (hdr_wt_cols == '0);

  logic last_k, last_j, last_i;
  assign last_k = (k_reg == in_cols_reg - ONE_D);
  assign last_j = (j_reg == wt_rows_reg - ONE_D);
  assign last_i = (i_reg == in_rows_reg - ONE_D);

  // Row pointers for the next (i,j): the input row only moves when j wraps
  logic [ADDR_W-1:0] in_cols_a, wt_cols_a, in_ptr_next, wt_ptr_next;
  assign in_cols_a = ADDR_W'(in_cols_reg);
  assign wt_cols_a = ADDR_W'(wt_cols_reg);
  always_comb begin
    in_ptr_next = in_row_ptr_reg;
    wt_ptr_next = wt_row_ptr_reg + wt_cols_a;
    if (last_j) begin
      in_ptr_next = in_row_ptr_reg + in_cols_a;
      wt_ptr_next = wt_base_reg + ONE_A;
    end
  end

  // ---------------- MAC datapath ----------------
  // Issue tags travel RD_LAT stages so they line up with the returned data.
  logic issue_vld, issue_first;
  assign issue_vld   = (state_reg == DOT_ISSUE);
  assign issue_first = (state_reg == DOT_ISSUE) && (k_reg == '0);

  logic [RD_LAT:0] vld_tap, first_tap;
  assign vld_tap[0]   = issue_vld;
  assign first_tap[0] = issue_first;

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_lat
      logic vld_reg, first_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_reg   <= 1'b0;
          first_reg <= 1'b0;
        end else begin
          vld_reg   <= vld_tap[gi];
          first_reg <= first_tap[gi];
        end
      end
      assign vld_tap[gi+1]   = vld_reg;
      assign first_tap[gi+1] = first_reg;
    end
  endgenerate

  logic signed [DATA_W-1:0] in_data_reg, wt_data_reg;
  logic                     mac_vld_reg, mac_first_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  assign prod     = PW'(in_data_reg) * PW'(wt_data_reg);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_data_reg   <= '0;
      wt_data_reg   <= '0;
      mac_vld_reg   <= 1'b0;
      mac_first_reg <= 1'b0;
      acc_reg       <= '0;
    end else begin
      in_data_reg   <= in_rd_data[DATA_W-1:0];
      wt_data_reg   <= wt_rd_data[DATA_W-1:0];
      mac_vld_reg   <= vld_tap[RD_LAT];
      mac_first_reg <= first_tap[RD_LAT];
      if (mac_vld_reg)
        acc_reg <= mac_first_reg ? prod_ext : acc_reg + prod_ext;
    end
  end

  // Result reduction to the write width
  logic [PW-1:0] res_reduced;
`ifdef PARAM_MAC_SATURATE_EN
  logic [ACC_W-PW:0] acc_top;
  assign acc_top = acc_reg[ACC_W-1:PW-1];
  always_comb begin
    res_reduced = acc_reg[PW-1:0];
    // Fits only when every bit above the result sign matches it
    if (!((&acc_top) || !(|acc_top)))
      res_reduced = acc_reg[ACC_W-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end
`else
  assign res_reduced = acc_reg[PW-1:0];
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ready_reg       <= 1'b1;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      res_wr_en_reg   <= 1'b0;
      res_wr_addr_reg <= '0;
      res_wr_data_reg <= '0;
      in_rd_addr_reg  <= '0;
      wt_rd_addr_reg  <= '0;
      in_base_reg     <= '0;
      wt_base_reg     <= '0;
      res_base_reg    <= '0;
      in_row_ptr_reg  <= '0;
      wt_row_ptr_reg  <= '0;
      res_addr_reg    <= '0;
      in_rows_reg     <= '0;
      in_cols_reg     <= '0;
      wt_rows_reg     <= '0;
      wt_cols_reg     <= '0;
      i_reg           <= '0;
      j_reg           <= '0;
      k_reg           <= '0;
      wait_cnt_reg    <= '0;
    end else begin
      done_reg      <= 1'b0;
      res_wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          in_base_reg    <= in_base;
          wt_base_reg    <= wt_base;
          res_base_reg   <= res_base;
          in_rd_addr_reg <= in_base;
          wt_rd_addr_reg <= wt_base;
          err_reg        <= 1'b0;
          ready_reg      <= 1'b0;
          wait_cnt_reg   <= '0;
          state_reg      <= HDR_RD;
        end
        HDR_RD: begin
          if (wait_cnt_reg == HDR_LAST) state_reg <= HDR_SAVE;
          else wait_cnt_reg <= wait_cnt_reg + 3'd1;
        end
        HDR_SAVE: begin
          in_rows_reg <= hdr_in_rows;
          in_cols_reg <= hdr_in_cols;
          wt_rows_reg <= hdr_wt_rows;
          wt_cols_reg <= hdr_wt_cols;
          if (hdr_bad) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            in_row_ptr_reg <= in_base_reg + ONE_A;
            wt_row_ptr_reg <= wt_base_reg + ONE_A;
            in_rd_addr_reg <= in_base_reg + ONE_A;
            wt_rd_addr_reg <= wt_base_reg + ONE_A;
            res_addr_reg   <= res_base_reg;
            state_reg      <= DOT_ISSUE;
          end
        end
        DOT_ISSUE: begin
          if (last_k) begin
            wait_cnt_reg <= '0;
            state_reg    <= DOT_DRAIN;
          end else begin
            k_reg          <= k_reg + ONE_D;
            in_rd_addr_reg <= in_rd_addr_reg + ONE_A;
            wt_rd_addr_reg <= wt_rd_addr_reg + ONE_A;
          end
        end
        DOT_DRAIN: begin
          // Accumulator is final on the last drain cycle
          if (wait_cnt_reg == DRAIN_LAST) begin
            res_wr_en_reg   <= 1'b1;
            res_wr_addr_reg <= res_addr_reg;
            res_wr_data_reg <= res_reduced;
            state_reg       <= WRITE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
          end
        end
        WRITE: begin
          k_reg        <= '0;
          res_addr_reg <= res_addr_reg + ONE_A;
          if (last_j && last_i) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            j_reg          <= last_j ? '0 : j_reg + ONE_D;
            i_reg          <= last_j ? i_reg + ONE_D : i_reg;
            in_row_ptr_reg <= in_ptr_next;
            wt_row_ptr_reg <= wt_ptr_next;
            in_rd_addr_reg <= in_ptr_next;
            wt_rd_addr_reg <= wt_ptr_next;
            state_reg      <= DOT_ISSUE;
          end
        end
        FINISH: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready       = ready_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign in_rd_addr  = in_rd_addr_reg;
  assign wt_rd_addr  = wt_rd_addr_reg;
  assign res_wr_en   = res_wr_en_reg;
  assign res_wr_addr = res_wr_addr_reg;
  assign res_wr_data = res_wr_data_reg;
  assign in_rows     = in_rows_reg;
  assign in_cols     = in_cols_reg;
  assign wt_rows     = wt_rows_reg;
  assign wt_cols     = wt_cols_reg;

endmodule

// File: tb/tb_param_mac_engine.sv
// Bench: two engines (RD_LAT=1 and RD_LAT=4) driven with the same jobs over a
// shared SRAM image; write streams are compared against a matrix-product model.
module tb_param_mac_engine;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int ACCW = 40;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  logic [AW-1:0] in_base, wt_base, res_base;

  logic ready_a, done_a, err_a, res_wr_en_a;
  logic [AW-1:0] in_rd_addr_a, wt_rd_addr_a, res_wr_addr_a;
  logic [31:0] in_rd_data_a, wt_rd_data_a, res_wr_data_a;
  logic [DW-1:0] in_rows_a, in_cols_a, wt_rows_a, wt_cols_a;

  logic ready_b, done_b, err_b, res_wr_en_b;
  logic [AW-1:0] in_rd_addr_b, wt_rd_addr_b, res_wr_addr_b;
  logic [31:0] in_rd_data_b, wt_rd_data_b, res_wr_data_b;
  logic [DW-1:0] in_rows_b, in_cols_b, wt_rows_b, wt_cols_b;

  param_mac_engine #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .ready(ready_a), .done(done_a), .err(err_a),
    .in_base(in_base), .wt_base(wt_base), .res_base(res_base),
    .in_rd_addr(in_rd_addr_a), .wt_rd_addr(wt_rd_addr_a),
    .in_rd_data(in_rd_data_a), .wt_rd_data(wt_rd_data_a),
    .res_wr_en(res_wr_en_a), .res_wr_addr(res_wr_addr_a), .res_wr_data(res_wr_data_a),
    .in_rows(in_rows_a), .in_cols(in_cols_a), .wt_rows(wt_rows_a), .wt_cols(wt_cols_a));

  param_mac_engine #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .RD_LAT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .ready(ready_b), .done(done_b), .err(err_b),
    .in_base(in_base), .wt_base(wt_base), .res_base(res_base),
    .in_rd_addr(in_rd_addr_b), .wt_rd_addr(wt_rd_addr_b),
    .in_rd_data(in_rd_data_b), .wt_rd_data(wt_rd_data_b),
    .res_wr_en(res_wr_en_b), .res_wr_addr(res_wr_addr_b), .res_wr_data(res_wr_data_b),
    .in_rows(in_rows_b), .in_cols(in_cols_b), .wt_rows(wt_rows_b), .wt_cols(wt_cols_b));

  // SRAM image and read-latency models
  logic [31:0] mem [0:4095];
  logic [31:0] in_pipe_b [4];
  logic [31:0] wt_pipe_b [4];

  always @(posedge clk) begin
    in_rd_data_a <= mem[in_rd_addr_a];
    wt_rd_data_a <= mem[wt_rd_addr_a];
    in_pipe_b[0] <= mem[in_rd_addr_b];
    wt_pipe_b[0] <= mem[wt_rd_addr_b];
    for (int s = 1; s < 4; s++) begin
      in_pipe_b[s] <= in_pipe_b[s-1];
      wt_pipe_b[s] <= wt_pipe_b[s-1];
    end
  end
  assign in_rd_data_b = in_pipe_b[3];
  assign wt_rd_data_b = wt_pipe_b[3];

  // Write / done monitors
  logic [AW-1:0] wa_q_a[$], wa_q_b[$], exp_addr[$];
  logic [31:0]   wd_q_a[$], wd_q_b[$], exp_data[$];
  int done_cnt_a, done_cnt_b;
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    if (res_wr_en_a === 1'b1) begin wa_q_a.push_back(res_wr_addr_a); wd_q_a.push_back(res_wr_data_a); end
    if (res_wr_en_b === 1'b1) begin wa_q_b.push_back(res_wr_addr_b); wd_q_b.push_back(res_wr_data_b); end
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q_a.delete(); wd_q_a.delete(); wa_q_b.delete(); wd_q_b.delete();
    done_cnt_a = 0; done_cnt_b = 0;
  endtask

  task automatic load_rand(input logic [AW-1:0] base, input int rows, input int cols);
    mem[base] = {16'(rows), 16'(cols)};
    for (int e = 0; e < rows * cols; e++) mem[AW'(int'(base) + 1 + e)] = $urandom();
  endtask

  task automatic load_vals(input logic [AW-1:0] base, input int rows, input int cols, input int v[]);
    mem[base] = {16'(rows), 16'(cols)};
    for (int e = 0; e < rows * cols; e++) mem[AW'(int'(base) + 1 + e)] = {16'h0, 16'(v[e])};
  endtask

  // Wrap to the accumulator width, then reduce to the 32-bit result
  function automatic logic [31:0] reduce(input longint s);
    longint w;
    w = (s <<< (64 - ACCW)) >>> (64 - ACCW);
`ifdef PARAM_MAC_SATURATE_EN
    if (w > SMAX) return 32'h7FFF_FFFF;
    if (w < SMIN) return 32'h8000_0000;
`endif
    return w[31:0];
  endfunction

  // Reference: plain matrix product R = IN * WT^T read from the SRAM image
  task automatic model(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input logic [AW-1:0] rb);
    int ir, ic, wr, wc;
    longint s;
    logic signed [15:0] x, y;
    exp_addr.delete(); exp_data.delete();
    ir = int'(mem[ib][31:16]); ic = int'(mem[ib][15:0]);
    wr = int'(mem[wb][31:16]); wc = int'(mem[wb][15:0]);
    if (ic != wc || ir == 0 || ic == 0 || wr == 0 || wc == 0) return;
    for (int i = 0; i < ir; i++)
      for (int j = 0; j < wr; j++) begin
        s = 0;
        for (int k = 0; k < ic; k++) begin
          x = mem[AW'(int'(ib) + 1 + i * ic + k)][15:0];
          y = mem[AW'(int'(wb) + 1 + j * wc + k)][15:0];
          s += longint'(x) * longint'(y);
        end
        exp_addr.push_back(AW'(int'(rb) + i * wr + j));
        exp_data.push_back(reduce(s));
      end
  endtask

  task automatic run_job(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input logic [AW-1:0] rb,
                         input bit hold, input bit exp_err, input string tag);
    int cyc;
    bit fin;
    int n;
    clear_mon();
    @(negedge clk);
    in_base = ib; wt_base = wb; res_base = rb; start = 1'b1;
    cyc = 0; fin = 0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!hold || done_a === 1'b1) start = 1'b0;
      if (done_cnt_a > 0 && done_cnt_b > 0 && ready_a === 1'b1 && ready_b === 1'b1) fin = 1;
    end
    start = 1'b0;
    check({tag, " finished"}, 64'(fin), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, " done_a count"}, 64'(done_cnt_a), 64'd1);
    check({tag, " done_b count"}, 64'(done_cnt_b), 64'd1);
    check({tag, " err_a"}, 64'(err_a), 64'(exp_err));
    check({tag, " err_b"}, 64'(err_b), 64'(exp_err));
    check({tag, " writes_a"}, 64'(wa_q_a.size()), 64'(exp_addr.size()));
    check({tag, " writes_b"}, 64'(wa_q_b.size()), 64'(exp_addr.size()));
    n = exp_addr.size();
    if (wa_q_a.size() < n) n = wa_q_a.size();
    if (wa_q_b.size() < n) n = wa_q_b.size();
    for (int e = 0; e < n; e++) begin
      check($sformatf("%s wr_a[%0d]", tag, e), {wa_q_a[e], wd_q_a[e]}, {exp_addr[e], exp_data[e]});
      check($sformatf("%s wr_b[%0d]", tag, e), {wa_q_b[e], wd_q_b[e]}, {exp_addr[e], exp_data[e]});
    end
    $display("job %s: writes_a=%0d writes_b=%0d err_a=%0b err_b=%0b", tag, wa_q_a.size(), wa_q_b.size(), err_a, err_b);
  endtask

  task automatic load_basic();
    load_vals(12'h010, 2, 3, '{1, 2, 3, 4, 5, 6});
    load_vals(12'h040, 2, 3, '{1, 0, 1, 0, 1, 0});
    exp_addr.delete(); exp_data.delete();
    exp_addr = '{12'h100, 12'h101, 12'h102, 12'h103};
    exp_data = '{32'd4, 32'd2, 32'd10, 32'd5};
  endtask

  typedef struct {
    int ir, ic, wr, wc;
    logic [AW-1:0] ib, wb, rb;
    bit exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2, 3, 2, 3, 12'h010, 12'h040, 12'h100, 1'b0};
    tbl[1] = '{3, 1, 2, 1, 12'h020, 12'h030, 12'hFFE, 1'b0};
    tbl[2] = '{4, 5, 3, 5, 12'hFFA, 12'h050, 12'h200, 1'b0};
    tbl[3] = '{1, 4, 3, 4, 12'h060, 12'h080, 12'h300, 1'b0};
    tbl[4] = '{2, 3, 2, 4, 12'h010, 12'h040, 12'h100, 1'b1};
    tbl[5] = '{0, 3, 2, 3, 12'h010, 12'h040, 12'h100, 1'b1};
    tbl[6] = '{2, 0, 2, 0, 12'h010, 12'h040, 12'h100, 1'b1};
    tbl[7] = '{2, 3, 0, 3, 12'h010, 12'h040, 12'h100, 1'b1};
    tbl[8] = '{2, 2, 5, 2, 12'h0A0, 12'h0C0, 12'h400, 1'b0};

    for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
    reset = 1'b1; start = 1'b0; in_base = '0; wt_base = '0; res_base = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst flags_a", {ready_a, done_a, err_a, res_wr_en_a}, 64'b1000);
    check("rst flags_b", {ready_b, done_b, err_b, res_wr_en_b}, 64'b1000);
    check("rst addrs_a", {in_rd_addr_a, wt_rd_addr_a, res_wr_addr_a, res_wr_data_a}, 64'd0);
    check("rst addrs_b", {in_rd_addr_b, wt_rd_addr_b, res_wr_addr_b, res_wr_data_b}, 64'd0);
    check("rst dims_a", {in_rows_a, in_cols_a, wt_rows_a, wt_cols_a}, 64'd0);
    check("rst dims_b", {in_rows_b, in_cols_b, wt_rows_b, wt_cols_b}, 64'd0);

    // Worked example, start held high through the job
    load_basic();
    run_job(12'h010, 12'h040, 12'h100, 1'b1, 1'b0, "basic_hold");
    check("basic dims_a", {in_rows_a, in_cols_a, wt_rows_a, wt_cols_a}, {16'd2, 16'd3, 16'd2, 16'd3});
    check("basic dims_b", {in_rows_b, in_cols_b, wt_rows_b, wt_cols_b}, {16'd2, 16'd3, 16'd2, 16'd3});

    // Column mismatch is rejected; err stays up while idle
    load_vals(12'h010, 2, 3, '{1, 2, 3, 4, 5, 6});
    load_vals(12'h040, 2, 4, '{1, 1, 1, 1, 1, 1, 1, 1});
    exp_addr.delete(); exp_data.delete();
    run_job(12'h010, 12'h040, 12'h100, 1'b0, 1'b1, "mismatch");
    repeat (3) @(negedge clk);
    check("err held_a", 64'(err_a), 64'd1);
    check("err held_b", 64'(err_b), 64'd1);

    // Table of shapes with random contents
    for (int t = 0; t < 9; t++) begin
      load_rand(tbl[t].ib, tbl[t].ir, tbl[t].ic);
      load_rand(tbl[t].wb, tbl[t].wr, tbl[t].wc);
      model(tbl[t].ib, tbl[t].wb, tbl[t].rb);
      run_job(tbl[t].ib, tbl[t].wb, tbl[t].rb, 1'b0, tbl[t].exp_err, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d dims_a", t), {in_rows_a, in_cols_a, wt_rows_a, wt_cols_a},
            {16'(tbl[t].ir), 16'(tbl[t].ic), 16'(tbl[t].wr), 16'(tbl[t].wc)});
      check($sformatf("tbl%0d dims_b", t), {in_rows_b, in_cols_b, wt_rows_b, wt_cols_b},
            {16'(tbl[t].ir), 16'(tbl[t].ic), 16'(tbl[t].wr), 16'(tbl[t].wc)});
    end

    // Long dot product of max-positive values: saturate vs. wrap
    mem[12'h000] = {16'd1, 16'd256};
    mem[12'h200] = {16'd1, 16'd256};
    for (int e = 1; e <= 256; e++) begin
      mem[e] = 32'h0000_7FFF;
      mem[12'h200 + e] = 32'h0000_7FFF;
    end
    exp_addr.delete(); exp_data.delete();
    exp_addr.push_back(12'h800);
`ifdef PARAM_MAC_SATURATE_EN
    exp_data.push_back(32'h7FFF_FFFF);
`else
    exp_data.push_back(32'hFF00_0100);
`endif
    run_job(12'h000, 12'h200, 12'h800, 1'b0, 1'b0, "k256");

    // Reset mid-job: five cycles into DOT_ISSUE of the RD_LAT=1 engine
    load_rand(12'h010, 2, 10);
    load_rand(12'h100, 2, 10);
    clear_mon();
    @(negedge clk);
    in_base = 12'h010; wt_base = 12'h100; res_base = 12'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst ready_a", 64'(ready_a), 64'd1);
    check("midrst ready_b", 64'(ready_b), 64'd1);
    repeat (40) @(negedge clk);
    check("midrst writes", 64'(wa_q_a.size() + wa_q_b.size()), 64'd0);
    check("midrst dones", 64'(done_cnt_a + done_cnt_b), 64'd0);
    $display("job midrst: writes=%0d dones=%0d", wa_q_a.size() + wa_q_b.size(), done_cnt_a + done_cnt_b);

    load_basic();
    run_job(12'h010, 12'h040, 12'h100, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
